// File: rtl/router_fifo_pkg.sv
// Shared constants and helpers for the 1x3 router output-port buffers.
// Latency: none (declarations only).
// Backpressure: n/a.
//
// Package router_pkg: buffer geometry, header field layout, packet-length helper.
package router_pkg;

   localparam int FIFO_DEPTH = 16;
   localparam int DATA_W     = 8;

   // Header byte layout: [7:2] payload length, [1:0] destination address.
   localparam int LEN_MSB = 7;
   localparam int LEN_LSB = 2;
   localparam int ADDR_W  = 2;

   // Address 2'b11 is not a valid destination.
   localparam logic [ADDR_W-1:0] ADDR_RSVD = 2'b11;

   localparam int CNT_W = LEN_MSB - LEN_LSB + 1;
   typedef logic [CNT_W-1:0] pkt_cnt_t;

   // Bytes still to drain after the header: payload length plus the parity byte.
   function automatic pkt_cnt_t hdr_to_cnt(input logic [LEN_MSB:LEN_LSB] len);
      return len + pkt_cnt_t'(1);
   endfunction

endpackage

// File: rtl/router_fifo_if.sv
// Byte bus between the router register stage, one output buffer and its reader.
// Latency: none (wires only).
// Backpressure: full/empty flags; the writer and reader must respect them.
//
// Signals: write_enb, read_enb, lfd_state, data_in (writer/reader -> buffer);
//          full, empty, data_out (buffer -> writer/reader).
interface router_fifo_if
   import router_pkg::*;
#(
   parameter int DATA_W = router_pkg::DATA_W
);

   logic              write_enb;
   logic              read_enb;
   logic              lfd_state;
   logic [DATA_W-1:0] data_in;
   logic              full;
   logic              empty;
   logic [DATA_W-1:0] data_out;

   modport master (
      output write_enb, read_enb, lfd_state, data_in,
      input  full, empty, data_out
   );

   modport slave (
      input  write_enb, read_enb, lfd_state, data_in,
      output full, empty, data_out
   );

endinterface

// File: rtl/router_fifo_mem.sv
// Storage array for one output buffer: synchronous write, registered read.
// Latency: 1 clock from rd_en_i to rd_word_o.
// Backpressure: none; the caller gates wr_en_i/rd_en_i with full/empty.
//
// Ports: clock; wr_en_i/wr_addr_i/wr_word_i write port;
//        rd_en_i/rd_addr_i read port; rd_word_o registered read word.
module router_fifo_mem
   import router_pkg::*;
#(
   parameter int DEPTH  = FIFO_DEPTH,
   parameter int WORD_W = router_pkg::DATA_W + 1,
   localparam int AW    = $clog2(DEPTH)
) (
   input  logic              clock,
   input  logic              wr_en_i,
   input  logic [AW-1:0]     wr_addr_i,
   input  logic [WORD_W-1:0] wr_word_i,
   input  logic              rd_en_i,
   input  logic [AW-1:0]     rd_addr_i,
   output logic [WORD_W-1:0] rd_word_o
);

   logic [WORD_W-1:0] mem_q [DEPTH];
   logic [WORD_W-1:0] rd_word_q;

   // No reset on the array or read register: the owner tracks validity.
   always_ff @(posedge clock) begin
      if (wr_en_i) begin
         mem_q[wr_addr_i] <= wr_word_i;
      end
      if (rd_en_i) begin
         rd_word_q <= mem_q[rd_addr_i];
      end
   end

   assign rd_word_o = rd_word_q;

endmodule

// File: rtl/router_fifo.sv
// Per-port output buffer of the 1x3 router: stores header-tagged bytes and
// drives them to the destination reader, idling the bus once a packet drains.
// Latency: 1 clock write-to-flag, 1 clock read_enb-to-data_out.
// Backpressure: writes dropped while full, reads ignored while empty.
//
// Ports: clock, resetn (sync, active-low), soft_reset (sync flush),
//        bus (router_fifo_if.slave: write_enb, read_enb, lfd_state, data_in,
//        full, empty, data_out).
// Build option ROUTER_FIFO_TRISTATE_EN: idle data_out is all-Z instead of zero.
module router_fifo
   import router_pkg::*;
#(
   parameter int DEPTH  = FIFO_DEPTH,
   parameter int DATA_W = router_pkg::DATA_W
) (
   input  logic          clock,
   input  logic          resetn,
   input  logic          soft_reset,
   router_fifo_if.slave  bus
);

   localparam int AW = $clog2(DEPTH);
   localparam int PW = AW + 1;

`ifdef ROUTER_FIFO_TRISTATE_EN
   localparam logic [DATA_W-1:0] IDLE_VAL = 'z;
`else
   localparam logic [DATA_W-1:0] IDLE_VAL = '0;
`endif

   logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
   logic            lfd_q;
   logic            rd_pend_q;   // a read was accepted on the previous edge
   pkt_cnt_t        pkt_cnt_q;   // count before the pending read is applied
   pkt_cnt_t        pkt_cnt;     // architectural count, including the pending read
   logic            idle_q, idle_d;
   logic            empty_w, full_w;
   logic            wr_acc, rd_acc;
   logic            flush;
   logic [DATA_W:0] rd_word;

   assign flush   = !resetn || soft_reset;
   assign empty_w = (wr_ptr_q == rd_ptr_q);
   assign full_w  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                    (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
   assign wr_acc  = bus.write_enb && !full_w;
   assign rd_acc  = bus.read_enb && !empty_w;

   router_fifo_mem #(
      .DEPTH  (DEPTH),
      .WORD_W (DATA_W + 1)
   ) u_mem (
      .clock     (clock),
      .wr_en_i   (wr_acc && !flush),
      .wr_addr_i (wr_ptr_q[AW-1:0]),
      .wr_word_i ({lfd_q, bus.data_in}),
      .rd_en_i   (rd_acc && !flush),
      .rd_addr_i (rd_ptr_q[AW-1:0]),
      .rd_word_o (rd_word)
   );

   // The read word only becomes visible one clock after the read, so the
   // counter update for that read is folded in combinationally here; this
   // keeps pkt_cnt aligned with the edge on which the read was accepted.
   always_comb begin
      pkt_cnt = pkt_cnt_q;
      if (rd_pend_q) begin
         if (rd_word[DATA_W]) begin
            pkt_cnt = hdr_to_cnt(rd_word[LEN_MSB:LEN_LSB]);
         end else if (pkt_cnt_q != '0) begin
            pkt_cnt = pkt_cnt_q - pkt_cnt_t'(1);
         end
      end
   end

   always_comb begin
      wr_ptr_d = wr_ptr_q + PW'(wr_acc);
      rd_ptr_d = rd_ptr_q + PW'(rd_acc);
      idle_d   = idle_q;
      if (rd_acc) begin
         idle_d = 1'b0;
      end else if (pkt_cnt == '0) begin
         idle_d = 1'b1;
      end
   end

   always_ff @(posedge clock) begin
      if (flush) begin
         wr_ptr_q  <= '0;
         rd_ptr_q  <= '0;
         lfd_q     <= 1'b0;
         rd_pend_q <= 1'b0;
         pkt_cnt_q <= '0;
         idle_q    <= 1'b1;
      end else begin
         wr_ptr_q  <= wr_ptr_d;
         rd_ptr_q  <= rd_ptr_d;
         lfd_q     <= bus.lfd_state;
         rd_pend_q <= rd_acc;
         pkt_cnt_q <= pkt_cnt;
         idle_q    <= idle_d;
      end
   end

   assign bus.full     = full_w;
   assign bus.empty    = empty_w;
   assign bus.data_out = idle_q ? IDLE_VAL : rd_word[DATA_W-1:0];

endmodule

// File: doc/router_fifo.md
# router_fifo

Per-port output buffer of the 1x3 router. It sits directly downstream of the router register stage: it captures each byte that stage drives on its `dout` bus, tags the packet header, and hands the bytes to the destination reader. Three instances exist, one per output port. Each instance tracks packet length so that its output bus goes idle once a packet has been fully drained.

## Interface
- `DEPTH`, 16: number of stored words; power of two.
- `DATA_W`, 8: payload byte width.
- `clock` in 1: single clock; all state updates on the rising edge.
- `resetn` in 1: reset, synchronous, active-low.
- `soft_reset` in 1: synchronous, active-high flush of this port after a read timeout.
- `write_enb` in 1: write request; `data_in` is captured when accepted.
- `read_enb` in 1: read request from the destination.
- `lfd_state` in 1: load-first-data state flag from the FSM; the header byte reaches `data_in` one clock later.
- `data_in` in DATA_W: byte from the register stage.
- `full` out 1: no free entry.
- `empty` out 1: no stored entry.
- `data_out` out DATA_W: registered read data.

## Operation
- Storage:
  - DEPTH entries of DATA_W+1 bits.
  - The extra MSB is the header flag, equal to `lfd_q`, i.e. `lfd_state` delayed one clock.
- Pointers:
  - Write and read pointers are log2(DEPTH)+1 bits wide.
  - `empty` when the pointers are equal.
  - `full` when the MSBs differ and the lower bits are equal.
  - Both flags are combinational from the pointers.
- Write:
  - Accepted iff `write_enb && !full`.
  - Stores {`lfd_q`, `data_in`} at the write pointer, then increments the pointer (wraps naturally).
- Read:
  - Accepted iff `read_enb && !empty`.
  - `data_out` <= stored byte; the read pointer increments.
- Packet counter (6-bit `pkt_cnt`):
  - Read of a word with header flag 1: load `data[7:2] + 1` (payload length plus parity byte).
  - Any other accepted read with `pkt_cnt != 0`: decrement.
  - Header value 0 loads 1.
- Idle bus:
  - If no read is accepted and `pkt_cnt == 0`, `data_out` takes the idle value (see Configuration).
  - Otherwise `data_out` holds its value.
- Simultaneous read and write:
  - Both proceed independently.
  - When `full`, the write is rejected even if a read occurs in the same cycle.
  - When `empty`, the read is rejected even if a write occurs in the same cycle.
- Priority: `resetn` low > `soft_reset` > normal operation.
- `soft_reset` action:
  - Clears both pointers, `pkt_cnt` and `lfd_q`.
  - `data_out` takes the idle value.
  - Memory contents are not cleared; they become unreachable.

## Timing
- Reset values: `data_out` = idle value, `full` = 0, `empty` = 1, pointers = 0, `pkt_cnt` = 0, `lfd_q` = 0.
- Write to flag update: 1 clock. `empty` deasserts in the cycle after the first accepted write.
- Read latency: 1 clock. `data_out` is valid in the cycle after `read_enb` is sampled with `!empty`.
- Header alignment:
  - A byte written one clock after `lfd_state` = 1 is tagged as the header.
  - `write_enb` must be high in that cycle.
- Full DEPTH: after 16 accepted writes with no reads, `full` = 1. The 17th write is dropped and the pointers are unchanged.
- Drain: a packet of payload length L occupies L+2 entries. On the read that returns the parity byte, `pkt_cnt` reaches 0. `data_out` goes idle on the next non-read cycle.
- Reset mid-packet: `soft_reset` or `resetn` takes effect on the same edge and discards any partially written or read packet.

## Configuration
- `ROUTER_FIFO_TRISTATE_EN`:
  - Defined: idle value of `data_out` is all-Z, for a shared bus.
  - Undefined (default): idle value is all-zero and no tri-state drivers are inferred.
- All other behaviour is identical in both builds.

## Structure
- Package `router_pkg`:
  - `FIFO_DEPTH` = 16 and `DATA_W` = 8.
  - Header field constants: `LEN_MSB` = 7, `LEN_LSB` = 2, `ADDR_W` = 2.
  - Reserved address value 2'b11.
- Sub-module `router_fifo_mem`:
  - Synchronous-write, registered-read dual-port array of DEPTH x (DATA_W+1).
  - Pointer, flag, counter and idle logic stay in `router_fifo`.

## Test plan
- Reset: hold `resetn` = 0 for 2 clocks, then release -> `empty` = 1, `full` = 0, `data_out` = 0 (or Z with the macro).
- Single packet:
  - Stimulus: `lfd_state` pulse, then write header 8'h0D (L = 3), payloads 8'hA1, 8'hA2, 8'hA3, parity 8'h0E.
  - Read all 5 -> `data_out` sequence 0D, A1, A2, A3, 0E.
  - `pkt_cnt` values 4, 3, 2, 1, 0; `data_out` idle on the next idle cycle.
- Full boundary: 16 writes without reads -> `full` = 1; the 17th write (8'hFF) is ignored; 16 reads return the original order; `empty` = 1 after the last read.
- Concurrent access with 8 entries held: `write_enb` and `read_enb` high for 10 clocks -> occupancy stays 8, no data loss, and ordering is preserved across pointer wrap.
- Soft reset: assert `soft_reset` after 2 of 5 bytes have been read -> the next cycle shows `empty` = 1 and `data_out` idle; a new header 8'h05 then reads back correctly.
